// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: takes one 64-bit key, applies PC-1 and streams the
// 16 round subkeys (PC-2 of the rotated C/D halves) one per handshake, in either order.
module des_key_sched_seq #(
  parameter int PARITY_CHECK = 1,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [63:0]      key_in,
  input  logic             key_dec,
  input  logic [TAG_W-1:0] key_tag,
  input  logic             abort,
  output logic             sk_valid,
  input  logic             sk_ready,
  output logic [47:0]      sk_data,
  output logic [3:0]       sk_idx,
  output logic             sk_last,
  output logic [TAG_W-1:0] sk_tag,
  output logic             parity_err
);

  typedef enum logic {IDLE, RUN} state_t;

  // Tables use FIPS bit numbering: bit 1 is the MSB of the source vector.
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,
                               1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27,
                              19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,
                               7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29,
                              21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,
                               3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8,
                              16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55,
                              30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53,
                              46, 42, 50, 36, 29, 32};

  state_t             state_reg, state_next;
  logic [27:0]        c_reg, c_next;
  logic [27:0]        d_reg, d_next;
  logic [3:0]         count_reg, count_next;
  logic               dec_reg, dec_next;
  logic [TAG_W-1:0]   tag_reg, tag_next;
  logic               perr_reg, perr_next;

  logic [55:0]        pc1_w;
  logic [55:0]        cd_w;
  logic [47:0]        pc2_w;
  logic [7:0]         byte_odd;
  logic               parity_ok;
  logic               key_accept;
  logic               sk_fire;
  logic               one_shift;

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic one);
    logic [27:0] r;
    if (left) r = one ? {x[26:0], x[27]}    : {x[25:0], x[27:26]};
    else      r = one ? {x[0],    x[27:1]}  : {x[1:0],  x[27:2]};
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_w[55-gi] = key_in[64-PC1[gi]];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2_w[47-gi] = cd_w[56-PC2[gi]];
    end
    for (gi = 0; gi < 8; gi++) begin : g_par
      assign byte_odd[gi] = ^key_in[8*gi +: 8];
    end
  endgenerate

  assign cd_w       = {c_reg, d_reg};
  assign parity_ok  = (PARITY_CHECK == 0) || (&byte_odd);
  assign key_ready  = (state_reg == IDLE) && !abort;
  assign key_accept = key_valid && key_ready;
  assign sk_valid   = (state_reg == RUN);
  assign sk_fire    = sk_valid && sk_ready && !abort;
  // Single-bit shifts fall on the same counts for both orders (rounds 2/9/16 forward, 16/9/2 backward).
  assign one_shift  = (count_reg == 4'd0) || (count_reg == 4'd7) || (count_reg == 4'd14);

  assign sk_data    = pc2_w;
  assign sk_idx     = dec_reg ? (4'd15 - count_reg) : count_reg;
  assign sk_last    = (state_reg == RUN) && (count_reg == 4'd15);
  assign sk_tag     = tag_reg;
  assign parity_err = perr_reg;

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    d_next     = d_reg;
    count_next = count_reg;
    dec_next   = dec_reg;
    tag_next   = tag_reg;
    perr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_accept) begin
          if (parity_ok) begin
            // Decrypt starts at C16/D16, which equal C0/D0 after the full 28-bit rotation.
            c_next     = key_dec ? pc1_w[55:28] : rot28(pc1_w[55:28], 1'b1, 1'b1);
            d_next     = key_dec ? pc1_w[27:0]  : rot28(pc1_w[27:0],  1'b1, 1'b1);
            count_next = 4'd0;
            dec_next   = key_dec;
            tag_next   = key_tag;
            state_next = RUN;
          end else begin
            perr_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (sk_fire) begin
          if (count_reg == 4'd15) begin
            state_next = IDLE;
          end else begin
            count_next = count_reg + 4'd1;
            c_next     = rot28(c_reg, !dec_reg, one_shift);
            d_next     = rot28(d_reg, !dec_reg, one_shift);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      count_reg <= '0;
      dec_reg   <= 1'b0;
      tag_reg   <= '0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      d_reg     <= d_next;
      count_reg <= count_next;
      dec_reg   <= dec_next;
      tag_reg   <= tag_next;
      perr_reg  <= perr_next;
    end
  end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Scoreboard bench for des_key_sched_seq: stimulus pushes expected subkey beats,
// a negedge monitor pops and compares on every accepted subkey.
module tb_des_key_sched_seq;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] ZKEY = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        key_valid, key_ready, key_dec, abort, sk_valid, sk_ready, sk_last, parity_err;
  logic [63:0] key_in;
  logic [3:0]  key_tag, sk_idx, sk_tag;
  logic [47:0] sk_data;

  logic        np_key_valid, np_key_ready, np_sk_valid, np_sk_last, np_parity_err;
  logic [3:0]  np_sk_idx, np_sk_tag;
  logic [47:0] np_sk_data;

  des_key_sched_seq #(.PARITY_CHECK(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .key_dec(key_dec), .key_tag(key_tag), .abort(abort),
    .sk_valid(sk_valid), .sk_ready(sk_ready), .sk_data(sk_data), .sk_idx(sk_idx),
    .sk_last(sk_last), .sk_tag(sk_tag), .parity_err(parity_err)
  );

  des_key_sched_seq #(.PARITY_CHECK(0), .TAG_W(4)) dut_np (
    .clk(clk), .rst_n(rst_n), .key_valid(np_key_valid), .key_ready(np_key_ready),
    .key_in(ZKEY), .key_dec(1'b0), .key_tag(4'h1), .abort(1'b0),
    .sk_valid(np_sk_valid), .sk_ready(1'b1), .sk_data(np_sk_data), .sk_idx(np_sk_idx),
    .sk_last(np_sk_last), .sk_tag(np_sk_tag), .parity_err(np_parity_err)
  );

  typedef struct packed {
    logic [47:0] data;
    logic [3:0]  idx;
    logic        last;
    logic [3:0]  tag;
  } beat_t;

  beat_t       exp_q[$];
  logic [47:0] np_q[$];
  logic [47:0] ks [16];
  int          checks = 0;
  int          passes = 0;
  bit          hold_pending = 1'b0;
  beat_t       held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic push_enc(input logic [3:0] t, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{ks[i], i[3:0], (i == 15), t});
  endtask

  task automatic push_dec(input logic [3:0] t);
    for (int j = 0; j < 16; j++) exp_q.push_back('{ks[15-j], 4'(15 - j), (j == 15), t});
  endtask

  // Called at posedge+1; leaves the key presented for exactly one cycle.
  task automatic send_key(input logic [63:0] k, input logic d, input logic [3:0] t, input bit expect_run);
    int n = 0;
    while (!key_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("key_ready_before_send", key_ready, 1);
    key_in = k; key_dec = d; key_tag = t; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    if (expect_run) check("latency1_valid", sk_valid, 1);
  endtask

  task automatic wait_drain(input bit rnd);
    int n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
      sk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    sk_ready = 1'b1;
    check("drain_in_time", (n < 400), 1);
    check("end_valid_low", sk_valid, 0);
    check("end_key_ready", key_ready, 1);
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n = 0;
    while (!(sk_valid && sk_idx == idx) && n < 100) begin @(posedge clk); #1; n++; end
    check("reach_idx", (n < 100), 1);
  endtask

  // Main scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending && sk_valid)
        check("stall_hold", {sk_data, sk_idx, sk_last, sk_tag}, held);
      hold_pending = 1'b0;
      if (sk_valid) check("key_ready_low_in_run", key_ready, 0);
      if (sk_valid && !abort) begin
        if (sk_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_beat: got %h idx %0d expected none", sk_data, sk_idx);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            $display("beat idx=%0d data=%h last=%0b tag=%h", sk_idx, sk_data, sk_last, sk_tag);
            check("beat", {sk_data, sk_idx, sk_last, sk_tag}, e);
          end
        end else begin
          hold_pending = 1'b1;
          held = '{sk_data, sk_idx, sk_last, sk_tag};
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  // Monitor for the parity-ignoring build.
  always @(negedge clk) begin
    if (rst_n && np_sk_valid) begin
      if (np_q.size() == 0) begin
        checks++;
        $display("FAIL np_unexpected_beat: got %h expected none", np_sk_data);
      end else begin
        logic [47:0] e;
        e = np_q.pop_front();
        $display("np beat idx=%0d data=%h", np_sk_idx, np_sk_data);
        check("np_beat", np_sk_data, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    ks = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
           48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
           48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
           48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; key_dec = 1'b0; key_tag = '0;
    abort = 1'b0; sk_ready = 1'b1; np_key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_ready", key_ready, 1);
    check("rst_sk_valid", sk_valid, 0);
    check("rst_sk_last", sk_last, 0);
    check("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;

    // Encrypt order, no stalls.
    push_enc(4'h3, 16);
    send_key(KEY, 1'b0, 4'h3, 1'b1);
    wait_drain(1'b0);

    // Decrypt order: exact reverse.
    push_dec(4'h5);
    send_key(KEY, 1'b1, 4'h5, 1'b1);
    wait_drain(1'b0);

    // Encrypt with random backpressure.
    push_enc(4'h7, 16);
    send_key(KEY, 1'b0, 4'h7, 1'b1);
    wait_drain(1'b1);

    // Bad parity key is rejected.
    send_key(ZKEY, 1'b0, 4'h2, 1'b0);
    check("perr_pulse", parity_err, 1);
    check("perr_no_valid", sk_valid, 0);
    @(posedge clk); #1;
    check("perr_one_cycle", parity_err, 0);
    for (int i = 0; i < 4; i++) begin
      check("perr_stays_idle", {sk_valid, key_ready}, 2'b01);
      @(posedge clk); #1;
    end

    // Parity-ignoring build streams all-zero subkeys for the zero key.
    for (int i = 0; i < 16; i++) np_q.push_back(48'h0);
    np_key_valid = 1'b1;
    @(posedge clk); #1;
    np_key_valid = 1'b0;
    for (int n = 0; n < 40 && np_q.size() != 0; n++) begin @(posedge clk); #1; end
    check("np_drained", np_q.size(), 0);

    // Abort on beat 5, then a new key streams from K1.
    push_enc(4'h6, 4);
    send_key(KEY, 1'b0, 4'h6, 1'b1);
    wait_idx(4'd4);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_valid_low", sk_valid, 0);
    check("abort_no_extra", exp_q.size(), 0);
    key_in = KEY; key_valid = 1'b1;
    #1;
    check("abort_blocks_ready", key_ready, 0);
    @(posedge clk); #1;
    key_valid = 1'b0; abort = 1'b0;
    check("abort_blocks_accept", sk_valid, 0);
    push_enc(4'h9, 16);
    send_key(KEY, 1'b0, 4'h9, 1'b1);
    wait_drain(1'b0);

    // Asynchronous reset during beat 8.
    push_enc(4'h2, 7);
    send_key(KEY, 1'b0, 4'h2, 1'b1);
    wait_idx(4'd7);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", {sk_valid, key_ready, sk_last, parity_err, sk_idx, sk_tag},
          {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0});
    check("arst_partial", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_enc(4'hA, 16);
    send_key(KEY, 1'b0, 4'hA, 1'b1);
    wait_drain(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
